// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-port ALU sharing arbiter: opcodes,
// opcode legality check and FSM state encoding.
package alu_share_arbiter_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_MIN = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MIN, OP_NOR: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ALU32.sv
// 32-bit ALU with a registered result and a combinational operand-equality flag.
module ALU32
   import alu_share_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic [3:0]  op,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic [31:0] result,
   output logic        zero
);

   logic [31:0] result_nxt;

   assign zero = (in1 == in2);

   always_comb begin
      result_nxt = 'x;
      case (op)
         OP_AND: result_nxt = in1 & in2;
         OP_OR:  result_nxt = in1 | in2;
         OP_ADD: result_nxt = in1 + in2;
         OP_SUB: result_nxt = in1 - in2;
         OP_MIN: result_nxt = (in1 < in2) ? in1 : in2;
         OP_NOR: result_nxt = ~(in1 | in2);
         default: result_nxt = 'x;
      endcase
   end

   always_ff @(posedge clk) begin
      result <= result_nxt;
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between ports A and B;
// one op in flight, response pulse three edges after the transfer edge.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter bit FIRST_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic [3:0]  a_op,
   input  logic [31:0] a_in1,
   input  logic [31:0] a_in2,
   input  logic        b_req,
   input  logic [3:0]  b_op,
   input  logic [31:0] b_in1,
   input  logic [31:0] b_in2,
   output logic        a_gnt,
   output logic        b_gnt,
   output logic        a_rsp_valid,
   output logic [31:0] a_rsp_result,
   output logic        a_rsp_zero,
   output logic        a_rsp_err,
   output logic        b_rsp_valid,
   output logic [31:0] b_rsp_result,
   output logic        b_rsp_zero,
   output logic        b_rsp_err,
   output logic        busy
);

   state_t      state, state_nxt;
   logic [3:0]  alu_op;
   logic [31:0] alu_in1, alu_in2;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        owner, last_owner;   // 0 = A, 1 = B
   logic        illegal_q, zero_q;
   logic [3:0]  sel_op;
   logic [31:0] sel_in1, sel_in2;
   logic [31:0] masked_result;

   ALU32 u_alu (
      .clk    (clk),
      .op     (alu_op),
      .in1    (alu_in1),
      .in2    (alu_in2),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // Grant uses only req, state and last_owner; operand muxing is kept separate.
   always_comb begin
      state_nxt = state;
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      case (state)
         S_IDLE: begin
            if (a_req && (!b_req || last_owner)) a_gnt = 1'b1;
            else if (b_req)                      b_gnt = 1'b1;
            if (a_gnt || b_gnt) state_nxt = S_EXEC;
         end
         S_EXEC:  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign sel_op        = b_gnt ? b_op  : a_op;
   assign sel_in1       = b_gnt ? b_in1 : a_in1;
   assign sel_in2       = b_gnt ? b_in2 : a_in2;
   assign masked_result = illegal_q ? '0 : alu_result;
   assign busy          = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         alu_op       <= '0;
         alu_in1      <= '0;
         alu_in2      <= '0;
         owner        <= 1'b0;
         last_owner   <= !FIRST_PRIO;
         illegal_q    <= 1'b0;
         zero_q       <= 1'b0;
         a_rsp_valid  <= 1'b0;
         a_rsp_result <= '0;
         a_rsp_zero   <= 1'b0;
         a_rsp_err    <= 1'b0;
         b_rsp_valid  <= 1'b0;
         b_rsp_result <= '0;
         b_rsp_zero   <= 1'b0;
         b_rsp_err    <= 1'b0;
      end else begin
         state       <= state_nxt;
         a_rsp_valid <= 1'b0;
         b_rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (a_gnt || b_gnt) begin
                  owner     <= b_gnt;
                  alu_op    <= sel_op;
                  alu_in1   <= sel_in1;
                  alu_in2   <= sel_in2;
                  illegal_q <= !op_legal(sel_op);
               end
            end
            S_EXEC: zero_q <= alu_zero;
            S_DONE: begin
               last_owner <= owner;
               if (owner) begin
                  b_rsp_valid  <= 1'b1;
                  b_rsp_result <= masked_result;
                  b_rsp_zero   <= zero_q;
                  b_rsp_err    <= illegal_q;
               end else begin
                  a_rsp_valid  <= 1'b1;
                  a_rsp_result <= masked_result;
                  a_rsp_zero   <= zero_q;
                  a_rsp_err    <= illegal_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: drivers push expected responses,
// a negedge monitor pops and checks value, arrival cycle and held outputs.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        a_req = 1'b0, b_req = 1'b0;
   logic [3:0]  a_op = '0, b_op = '0;
   logic [31:0] a_in1 = '0, a_in2 = '0, b_in1 = '0, b_in2 = '0;
   logic        a_gnt, b_gnt, a_rsp_valid, b_rsp_valid;
   logic [31:0] a_rsp_result, b_rsp_result;
   logic        a_rsp_zero, b_rsp_zero, a_rsp_err, b_rsp_err, busy;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic rst_q = 1'b1;
   logic [33:0] a_hold = '0, b_hold = '0;

   alu_share_arbiter #(.FIRST_PRIO(1'b0)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_op(a_op), .a_in1(a_in1), .a_in2(a_in2),
      .b_req(b_req), .b_op(b_op), .b_in1(b_in1), .b_in2(b_in2),
      .a_gnt(a_gnt), .b_gnt(b_gnt),
      .a_rsp_valid(a_rsp_valid), .a_rsp_result(a_rsp_result),
      .a_rsp_zero(a_rsp_zero), .a_rsp_err(a_rsp_err),
      .b_rsp_valid(b_rsp_valid), .b_rsp_result(b_rsp_result),
      .b_rsp_zero(b_rsp_zero), .b_rsp_err(b_rsp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (rst_q) begin
         a_hold = '0;
         b_hold = '0;
         qa.delete();
         qb.delete();
      end
      if (a_rsp_valid) begin
         if (qa.size() == 0) chk("a_unexpected_valid", 40'(a_rsp_valid), 40'd0);
         else begin
            e = qa.pop_front();
            chk("a_rsp", 40'({a_rsp_result, a_rsp_zero, a_rsp_err}), 40'({e.res, e.zero, e.err}));
            chk("a_rsp_cycle", 40'(cyc), 40'(e.cyc));
            a_hold = {e.res, e.zero, e.err};
         end
      end else
         chk("a_hold", 40'({a_rsp_result, a_rsp_zero, a_rsp_err}), 40'(a_hold));
      if (b_rsp_valid) begin
         if (qb.size() == 0) chk("b_unexpected_valid", 40'(b_rsp_valid), 40'd0);
         else begin
            e = qb.pop_front();
            chk("b_rsp", 40'({b_rsp_result, b_rsp_zero, b_rsp_err}), 40'({e.res, e.zero, e.err}));
            chk("b_rsp_cycle", 40'(cyc), 40'(e.cyc));
            b_hold = {e.res, e.zero, e.err};
         end
      end else
         chk("b_hold", 40'({b_rsp_result, b_rsp_zero, b_rsp_err}), 40'(b_hold));
   end

   task automatic push_exp(input bit p, input logic [31:0] res, input logic zero, input logic err);
      exp_t e;
      e.res = res; e.zero = zero; e.err = err;
      e.cyc = cyc + 3;   // transfer edge, EXEC edge, DONE edge, then sampled
      if (p) qb.push_back(e);
      else   qa.push_back(e);
   endtask

   // Called just after a negedge; waits (bounded) for grant then drops req.
   task automatic do_op(input bit p, input logic [3:0] op, input logic [31:0] i1,
                        input logic [31:0] i2, input logic [31:0] res,
                        input logic zero, input logic err);
      bit got = 0;
      if (p) begin b_req = 1; b_op = op; b_in1 = i1; b_in2 = i2; end
      else   begin a_req = 1; a_op = op; a_in1 = i1; a_in2 = i2; end
      for (int i = 0; i < 40 && !got; i++) begin
         #1;
         if ((p ? b_gnt : a_gnt) === 1'b1) begin
            push_exp(p, res, zero, err);
            got = 1;
         end
         @(negedge clk);
      end
      chk("grant_seen", 40'(got), 40'd1);
      if (p) b_req = 0;
      else   a_req = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      do_reset();
      #1;
      chk("reset_gnt", 40'({a_gnt, b_gnt}), 40'd0);
      chk("reset_busy", 40'(busy), 40'd0);
      chk("reset_valid", 40'({a_rsp_valid, b_rsp_valid}), 40'd0);
      @(negedge clk);

      // Single A add
      a_req = 1; a_op = 4'b0010; a_in1 = 5; a_in2 = 7;
      #1;
      chk("a_gnt_first", 40'({a_gnt, b_gnt}), 40'b10);
      push_exp(0, 32'd12, 1'b0, 1'b0);
      @(negedge clk);
      a_req = 0;
      chk("busy_exec", 40'(busy), 40'd1);
      repeat (3) @(negedge clk);

      // Both requesting continuously: alternate A, B, A, B
      do_reset();
      a_req = 1; a_op = 4'b0110; a_in1 = 10; a_in2 = 10;
      b_req = 1; b_op = 4'b0111; b_in1 = 3;  b_in2 = 9;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (k % 2 == 0) begin
            chk("rr_gnt", 40'({a_gnt, b_gnt}), 40'b10);
            push_exp(0, 32'd0, 1'b1, 1'b0);
         end else begin
            chk("rr_gnt", 40'({a_gnt, b_gnt}), 40'b01);
            push_exp(1, 32'd3, 1'b0, 1'b0);
         end
         repeat (3) @(negedge clk);
      end
      a_req = 0; b_req = 0;
      repeat (2) @(negedge clk);

      // Directed vectors, including NOR of zeros and an illegal opcode
      do_op(1, 4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      do_op(0, 4'b1111, 32'd1, 32'd2, 32'h0, 1'b0, 1'b1);
      do_op(0, 4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
      do_op(1, 4'b0000, 32'hF0F0_1234, 32'hFF00_FFFF, 32'hF000_1234, 1'b0, 1'b0);
      do_op(0, 4'b0001, 32'h0000_00A0, 32'h0000_000B, 32'h0000_00AB, 1'b0, 1'b0);
      do_op(1, 4'b0111, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      do_op(0, 4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0);
      repeat (4) @(negedge clk);

      // Reset during EXEC discards the op
      a_req = 1; a_op = 4'b0010; a_in1 = 1; a_in2 = 1;
      #1;
      chk("abort_gnt", 40'(a_gnt), 40'd1);
      @(negedge clk);
      a_req = 0;
      chk("abort_busy_exec", 40'(busy), 40'd1);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("abort_busy", 40'(busy), 40'd0);
      chk("abort_outputs", 40'({a_rsp_valid, a_rsp_result, a_rsp_zero, a_rsp_err}), 40'd0);
      repeat (4) @(negedge clk);
      do_op(1, 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
      repeat (4) @(negedge clk);

      // Request dropped before a grant edge
      a_req = 1; a_op = 4'b0010; a_in1 = 9; a_in2 = 9;
      #1;
      chk("drop_gnt_comb", 40'(a_gnt), 40'd1);
      #1;
      a_req = 0;
      #1;
      chk("drop_gnt_low", 40'(a_gnt), 40'd0);
      @(negedge clk);
      chk("drop_busy", 40'(busy), 40'd0);
      repeat (4) @(negedge clk);
      chk("drop_busy_later", 40'(busy), 40'd0);

      chk("qa_empty", 40'(qa.size()), 40'd0);
      chk("qb_empty", 40'(qb.size()), 40'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single registered 32-bit ALU between two requesters (port A, port B) with round-robin fairness. It accepts one operation at a time through a req/gnt handshake, sequences operands and opcode into the ALU, captures the registered result and the equality flag, and returns them to the owning port with a one-cycle response pulse. It sits between the execute-stage issue logic and the ALU instance.

## Interface
- FIRST_PRIO, 0, port that wins the first tie after reset (0 = A, 1 = B)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- a_req, b_req  in  1  request, level; held with operands until granted
- a_op, b_op  in  4  opcode
- a_in1, a_in2, b_in1, b_in2  in  32  operands
- a_gnt, b_gnt  out  1  combinational grant; transfer occurs on an edge where req && gnt
- a_rsp_valid, b_rsp_valid  out  1  one-cycle response pulse, registered
- a_rsp_result, b_rsp_result  out  32  result; held until that port's next response
- a_rsp_zero, b_rsp_zero  out  1  in1 == in2 for the completed op
- a_rsp_err, b_rsp_err  out  1  illegal opcode flag for the completed op
- busy  out  1  state != IDLE

## Operation
- Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 unsigned min (in1 < in2 ? in1 : in2), 1100 NOR. All other opcodes are illegal.
- FSM states: IDLE, EXEC, DONE.
- IDLE: if exactly one req is high, that port is granted. If both are high, grant goes to the port not in last_owner. On the transfer edge, latch op/in1/in2 into the ALU drive registers, latch owner and illegal flag, then go to EXEC. With no req, stay in IDLE. Grants are low outside IDLE.
- EXEC: ALU inputs are stable. Capture ALU Zero into zero_q. The ALU registers its Result on this edge. Go to DONE.
- DONE: capture ALU Result into the owner's rsp_result (forced to 0 if illegal), along with the owner's rsp_zero and rsp_err. Pulse the owner's rsp_valid. Update last_owner. Go to IDLE.
- The illegal flag does not change sequencing. An illegal op is still issued, and the ALU's X result is masked to 0.
- The non-owner port's response outputs are untouched.
- Reset values: state IDLE; gnts 0; all rsp_valid/rsp_zero/rsp_err 0; all rsp_result 0; busy 0; ALU drive registers 0 (op 0000); last_owner = !FIRST_PRIO.
- Reset mid-operation: the in-flight op is discarded, no rsp_valid is produced, and last_owner returns to its reset value.
- A req dropped before grant is not an error. A req held after transfer is treated as a new request at the next IDLE.

## Timing
- Edge E0: transfer (req && gnt in IDLE).
- Edge E1: EXEC.
- Edge E2: DONE.
- rsp_valid is high in the cycle after E2, for exactly one cycle.
- In that same cycle the FSM is in IDLE, so a new grant may be given. Sustained throughput is 1 op per 3 cycles.
- Back-to-back with both ports requesting: grants alternate A, B, A, …
- gnt depends combinationally on req, state and last_owner only. There is no combinational path from operands to gnt.

## Structure
- Shared package holds:
  - opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MIN, OP_NOR)
  - an op_legal function
  - FSM state encoding (2-bit)
- The ALU is instantiated inside as sub-module ALU32, clocked by clk. Its Result/Zero are consumed only by this block.
- The round-robin pick is small enough to stay inline. No further sub-modules.

## Test plan
- Reset, then a_req with op 0010, in1 5, in2 7 → a_gnt high in that cycle; a_rsp_valid in the cycle after the 3rd edge; a_rsp_result 12, a_rsp_zero 0; b outputs unchanged.
- Both req high continuously; A: 0110, 10, 10; B: 0111, 3, 9 → A first (FIRST_PRIO 0). A gives result 0, zero 1. B gives result 3, zero 0. Then the order alternates A, B, A, B; responses are 3 cycles apart.
- b_req with op 1100, in1 0, in2 0 → b_rsp_result FFFFFFFF, b_rsp_zero 1.
- a_req with illegal op 1111, in1 1, in2 2 → normal 3-cycle timing; a_rsp_err 1, a_rsp_result 0.
- Assert reset in EXEC of an A op → no a_rsp_valid; all outputs at reset values the next cycle; a following B request is served normally.
- a_req dropped in IDLE before being sampled with gnt → no transfer, state stays IDLE, busy 0.
